thread_regfile: RTL

//   Per-thread 16 x 8-bit register file; one instance per ALU/LSU lane inside a core.

---
 rtl/thread_regfile.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/thread_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : thread_regfile
//  Purpose  : Per-thread 16 x 8-bit register file for one ALU/LSU lane.
//             R0-R12 general purpose, R13 %blockIdx, R14 %blockDim,
//             R15 %threadIdx. Operands are captured in REQUEST and
//             results are written back in UPDATE.
//  Revision : 1.0 - initial release
// ============================================================================
module thread_regfile #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] block_id,
  input  logic [2:0] core_state,
  input  logic [3:0] decoded_rd_address,
  input  logic [3:0] decoded_rs_address,
  input  logic [3:0] decoded_rt_address,
  input  logic       decoded_reg_write_enable,
  input  logic [1:0] decoded_reg_input_mux,
  input  logic [7:0] decoded_immediate,
  input  logic [7:0] alu_out,
  input  logic [7:0] lsu_out,
  output logic [7:0] rs,
  output logic [7:0] rt
);

  // Core FSM encodings this block reacts to.
  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  // Writeback source select encodings.
  localparam logic [1:0] MUX_ALU    = 2'b00;
  localparam logic [1:0] MUX_MEMORY = 2'b01;
  localparam logic [1:0] MUX_CONST  = 2'b10;

  // Number of writable general-purpose registers (R0..R12).
  localparam int NUM_GPR = 13;

  // Read-only special register values; R14/R15 are pure constants.
  localparam logic [7:0] BLOCK_DIM  = 8'(THREADS_PER_BLOCK);
  localparam logic [7:0] THREAD_IDX = 8'(THREAD_ID);

  logic [7:0] gpr_q [NUM_GPR];
  logic [7:0] gpr_d [NUM_GPR];
  logic [7:0] block_idx_q;
  logic [7:0] block_idx_d;
  logic [7:0] rs_q;
  logic [7:0] rs_d;
  logic [7:0] rt_q;
  logic [7:0] rt_d;

  // Architectural view of all 16 registers, used by the operand read ports.
  logic [7:0] reg_view [16];

  logic [7:0] wb_data;
  logic       wb_src_valid;
  logic       wb_hit;

  generate
    for (genvar gi = 0; gi < NUM_GPR; gi++) begin : g_gpr_view
      assign reg_view[gi] = gpr_q[gi];
    end
  endgenerate

  assign reg_view[13] = block_idx_q;
  assign reg_view[14] = BLOCK_DIM;
  assign reg_view[15] = THREAD_IDX;

  // Select the writeback data source; the reserved encoding produces no write.
  always_comb begin
    wb_data      = 8'h00;
    wb_src_valid = 1'b0;
    case (decoded_reg_input_mux)
      MUX_ALU: begin
        wb_data      = alu_out;
        wb_src_valid = 1'b1;
      end
      MUX_MEMORY: begin
        wb_data      = lsu_out;
        wb_src_valid = 1'b1;
      end
      MUX_CONST: begin
        wb_data      = decoded_immediate;
        wb_src_valid = 1'b1;
      end
      default: begin
        wb_data      = 8'h00;
        wb_src_valid = 1'b0;
      end
    endcase
  end

  // A write lands only in UPDATE, on a general-purpose destination; writes
  // aimed at the special registers are silently discarded.
  assign wb_hit = enable
               && (core_state == ST_UPDATE)
               && decoded_reg_write_enable
               && (decoded_rd_address <= 4'd12)
               && wb_src_valid;

  // Next-state: track block_id, capture operands in REQUEST, write back in UPDATE.
  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) begin
      gpr_d[i] = gpr_q[i];
    end
    block_idx_d = block_idx_q;
    rs_d        = rs_q;
    rt_d        = rt_q;

    if (enable) begin
      block_idx_d = block_id;

      if (core_state == ST_REQUEST) begin
        rs_d = reg_view[decoded_rs_address];
        rt_d = reg_view[decoded_rt_address];
      end

      for (int i = 0; i < NUM_GPR; i++) begin
        if (wb_hit && (decoded_rd_address == 4'(i))) begin
          gpr_d[i] = wb_data;
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_q[i] <= 8'h00;
      end
      block_idx_q <= 8'h00;
      rs_q        <= 8'h00;
      rt_q        <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      block_idx_q <= block_idx_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
    end
  end

  assign rs = rs_q;
  assign rt = rt_q;

endmodule
`default_nettype wire
